// File: rtl/fir_mac_accumulator.sv
// FIR output accumulator: collects TAPS multiplier products over a valid/ready
// handshake, then rounds and saturates the widened sum to a Q1.9 sample.
module fir_mac_accumulator #(
  parameter int PROD_W = 20,
  parameter int TAPS   = 16,
  parameter int IDX_W  = 4,
  parameter int ACC_W  = 24,
  parameter int OUT_W  = 10,
  parameter int FRAC   = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [PROD_W-1:0] prod_in,
  input  logic              prod_valid,
  output logic              prod_ready,
  output logic [IDX_W-1:0]  tap_idx,
  output logic              busy,
  output logic [OUT_W-1:0]  y_out,
  output logic              y_valid,
  input  logic              y_ready,
  output logic              overflow
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, OUTPUT = 2'd2} stateT;

  // One guard bit above the accumulator keeps the rounding bias from wrapping.
  localparam int R_W = ACC_W + 1 - FRAC;
  localparam logic signed [ACC_W:0] ROUND_BIAS = (ACC_W+1)'(2 ** (FRAC - 1));
  localparam logic signed [R_W-1:0] Y_MAX = R_W'(2 ** (OUT_W - 1) - 1);
  localparam logic signed [R_W-1:0] Y_MIN = R_W'(-(2 ** (OUT_W - 1)));

  stateT                    stateR, nextStateS;
  logic signed [ACC_W-1:0]  accR;
  logic        [IDX_W-1:0]  tapIdxR;
  logic        [OUT_W-1:0]  yOutR;
  logic                     yValidR;
  logic                     overflowR;

  logic signed [ACC_W-1:0]  sumS;
  logic                     prodHsS;
  logic                     yHsS;
  logic                     lastTapS;
  logic                     clearAccS;
  logic        [OUT_W:0]    roundedS;

  // Returns {saturated, sample} for round-half-up then clamp to OUT_W bits.
  function automatic logic [OUT_W:0] roundSat(input logic signed [ACC_W-1:0] sum);
    logic signed [ACC_W:0] biased;
    logic signed [R_W-1:0] r;
    logic        [OUT_W:0] res;
    biased = $signed({sum[ACC_W-1], sum}) + ROUND_BIAS;
    r      = biased[ACC_W:FRAC];
    if (r > Y_MAX) begin
      res = {1'b1, 1'b0, {(OUT_W-1){1'b1}}};
    end else if (r < Y_MIN) begin
      res = {1'b1, 1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      res = {1'b0, r[OUT_W-1:0]};
    end
    return res;
  endfunction

  assign prod_ready = (stateR == ACCUM);
  assign busy       = (stateR != IDLE);
  assign tap_idx    = tapIdxR;
  assign y_out      = yOutR;
  assign y_valid    = yValidR;
  assign overflow   = overflowR;

  assign prodHsS  = prod_valid & prod_ready;
  assign yHsS     = yValidR & y_ready;
  assign lastTapS = (tapIdxR == IDX_W'(TAPS - 1));
  assign sumS     = accR + {{(ACC_W-PROD_W){prod_in[PROD_W-1]}}, prod_in};
  assign roundedS = roundSat(sumS);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateR <= IDLE;
    end else begin
      stateR <= nextStateS;
    end
  end

  // Next-state decode and frame-restart detection.
  always_comb begin
    nextStateS = stateR;
    clearAccS  = 1'b0;
    case (stateR)
      IDLE: begin
        if (start) begin
          nextStateS = ACCUM;
          clearAccS  = 1'b1;
        end else begin
          nextStateS = IDLE;
        end
      end
      ACCUM: begin
        if (prodHsS && lastTapS) begin
          nextStateS = OUTPUT;
        end else begin
          nextStateS = ACCUM;
        end
      end
      OUTPUT: begin
        if (yHsS && start) begin
          nextStateS = ACCUM;
          clearAccS  = 1'b1;
        end else if (yHsS) begin
          nextStateS = IDLE;
        end else begin
          nextStateS = OUTPUT;
        end
      end
      default: begin
        nextStateS = IDLE;
      end
    endcase
  end

  // Accumulator and tap counter advance only on product handshakes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      accR    <= '0;
      tapIdxR <= '0;
    end else if (clearAccS) begin
      accR    <= '0;
      tapIdxR <= '0;
    end else if (prodHsS) begin
      accR    <= sumS;
      tapIdxR <= tapIdxR + IDX_W'(1);
    end
  end

  // Output sample is captured with the final product and held until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      yOutR     <= '0;
      overflowR <= 1'b0;
      yValidR   <= 1'b0;
    end else if (prodHsS && lastTapS) begin
      yOutR     <= roundedS[OUT_W-1:0];
      overflowR <= roundedS[OUT_W];
      yValidR   <= 1'b1;
    end else if (yHsS) begin
      yValidR   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fir_mac_accumulator.sv
// Directed self-checking bench for fir_mac_accumulator with an output scoreboard.
module tb_fir_mac_accumulator;

  localparam int TAPS = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [19:0] prod_in = 20'd0;
  logic        prod_valid = 1'b0;
  logic        prod_ready;
  logic [3:0]  tap_idx;
  logic        busy;
  logic [9:0]  y_out;
  logic        y_valid;
  logic        y_ready = 1'b0;
  logic        overflow;

  int total = 0;
  int bad = 0;
  int lastCycles = 0;
  logic signed [19:0] vals [TAPS];
  logic [10:0] sbQ [$];

  fir_mac_accumulator dut (
    .clk(clk), .rst_n(rst_n), .start(start), .prod_in(prod_in),
    .prod_valid(prod_valid), .prod_ready(prod_ready), .tap_idx(tap_idx),
    .busy(busy), .y_out(y_out), .y_valid(y_valid), .y_ready(y_ready),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [10:0] model(input int sum);
    int r;
    logic [31:0] rb;
    r = (sum + 256) >>> 9;
    rb = r;
    if (r > 511) return {1'b1, 10'h1FF};
    else if (r < -512) return {1'b1, 10'h200};
    else return {1'b0, rb[9:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fill(input logic signed [19:0] v);
    for (int i = 0; i < TAPS; i++) vals[i] = v;
  endtask

  // Optionally pulses start, then feeds nProd products; gap inserts an idle cycle between them.
  task automatic feed(input bit doStart, input bit gap, input int nProd);
    int sum;
    int cycles;
    sum = 0;
    cycles = 0;
    if (doStart) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    check("entry_busy", busy, 1);
    check("entry_ready", prod_ready, 1);
    check("entry_tap", tap_idx, 0);
    for (int i = 0; i < nProd; i++) begin
      if (gap && i > 0) begin
        prod_valid = 1'b0;
        @(negedge clk);
        cycles++;
        check("gap_ready", prod_ready, 1);
      end
      check("tap_seq", tap_idx, i);
      prod_valid = 1'b1;
      prod_in = vals[i];
      sum += int'(vals[i]);
      if (i == TAPS - 1) sbQ.push_back(model(sum));
      @(negedge clk);
      cycles++;
    end
    prod_valid = 1'b0;
    lastCycles = cycles;
  endtask

  // Expects y_valid right after the last product, compares with scoreboard, optionally takes it.
  task automatic collect(input bit take);
    int w;
    logic [10:0] exp;
    w = 0;
    while (!y_valid && w < 8) begin
      @(negedge clk);
      w++;
    end
    check("y_valid_latency", w, 0);
    if (sbQ.size() == 0) begin
      check("sb_underflow", 1, 0);
      exp = 11'd0;
    end else begin
      exp = sbQ.pop_front();
    end
    check("y_out", y_out, exp[9:0]);
    check("overflow", overflow, exp[10]);
    check("tap_wrap", tap_idx, 0);
    check("out_ready_low", prod_ready, 0);
    if (take) begin
      y_ready = 1'b1;
      @(negedge clk);
      y_ready = 1'b0;
      check("idle_valid", y_valid, 0);
      check("idle_busy", busy, 0);
      check("idle_hold_y", y_out, exp[9:0]);
    end
  endtask

  initial begin
    logic [9:0] heldY;
    logic       heldOvf;

    #12;
    check("rst_busy", busy, 0);
    check("rst_ready", prod_ready, 0);
    check("rst_valid", y_valid, 0);
    check("rst_y", y_out, 0);
    check("rst_ovf", overflow, 0);
    check("rst_tap", tap_idx, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic frame: 16 x 460 -> 14.
    fill(20'sd460);
    feed(1'b1, 1'b0, TAPS);
    collect(1'b1);

    // Positive and negative saturation, small negative sum rounding to zero.
    fill(20'sh40000);
    feed(1'b1, 1'b0, TAPS);
    collect(1'b1);
    fill(20'shC0000);
    feed(1'b1, 1'b0, TAPS);
    collect(1'b1);
    fill(-20'sd1);
    feed(1'b1, 1'b0, TAPS);
    collect(1'b1);

    // Products on alternate cycles.
    fill(20'sd460);
    feed(1'b1, 1'b1, TAPS);
    check("gap_cycles", lastCycles, 31);
    collect(1'b1);

    // Mixed random products.
    for (int i = 0; i < TAPS; i++) vals[i] = 20'($urandom);
    feed(1'b1, 1'b0, TAPS);
    collect(1'b1);

    // Back-pressure with start ignored, then back-to-back restart.
    fill(20'sd1000);
    feed(1'b1, 1'b0, TAPS);
    collect(1'b0);
    heldY = y_out;
    heldOvf = overflow;
    start = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_valid", y_valid, 1);
      check("bp_y", y_out, heldY);
      check("bp_ovf", overflow, heldOvf);
      check("bp_no_accum", prod_ready, 0);
    end
    y_ready = 1'b1;
    @(negedge clk);
    y_ready = 1'b0;
    start = 1'b0;
    check("b2b_valid", y_valid, 0);
    fill(20'sd460);
    feed(1'b0, 1'b0, TAPS);
    collect(1'b1);

    // Asynchronous reset mid-frame, then a clean frame.
    fill(20'sh3FFFF);
    feed(1'b1, 1'b0, 7);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_ready", prod_ready, 0);
    check("arst_tap", tap_idx, 0);
    check("arst_valid", y_valid, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    fill(20'sd460);
    feed(1'b1, 1'b0, TAPS);
    collect(1'b1);

    check("sb_empty", sbQ.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fir_mac_accumulator.md
Name: fir_mac_accumulator

Overview:
Downstream consumer of the 10x10 signed Multiplier (20-bit product) in the ANC datapath. It sequences one FIR output computation: it issues tap indices and accepts TAPS products over a valid/ready handshake. Products accumulate in a widened register. The sum is then rounded and saturated back to the 10-bit Q1.9 sample format for the anti-noise output stage.

Parameters:
PROD_W, 20, product width from Multiplier (signed Q2.18)
TAPS, 16, products summed per output sample (power of 2)
IDX_W, 4, log2(TAPS), tap index width
ACC_W, 24, accumulator width = PROD_W + IDX_W (cannot overflow internally)
OUT_W, 10, output sample width (signed Q1.9)
FRAC, 9, right-shift applied to accumulator for output

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse: begin new accumulation (honoured in IDLE, or OUTPUT with y_ready)
prod_in  in  PROD_W  signed product from Multiplier.MulOut
prod_valid  in  1  prod_in valid
prod_ready  out  1  block accepts prod_in this cycle
tap_idx  out  IDX_W  index of the tap whose product is expected next (drives coeff/sample select)
busy  out  1  high in ACCUM and OUTPUT
y_out  out  OUT_W  rounded, saturated filter output
y_valid  out  1  y_out valid
y_ready  in  1  downstream accepts y_out
overflow  out  1  y_out was saturated; qualified by y_valid

Behaviour:
- Single clock domain. rst_n low asynchronously forces: state=IDLE, acc=0, tap_idx=0, prod_ready=0, busy=0, y_out=0, y_valid=0, overflow=0. Mid-operation reset discards the partial sum; no output is produced.
- States: IDLE, ACCUM, OUTPUT.
- IDLE: prod_ready=0, y_valid=0. start=1 -> ACCUM next cycle with acc=0 and tap_idx=0.
- ACCUM: prod_ready=1, combinationally constant in this state. Handshake = prod_valid & prod_ready.
  - On handshake: acc <= acc + sign_extend(prod_in); tap_idx <= tap_idx+1. No handshake: acc and tap_idx hold.
  - Handshake while tap_idx==TAPS-1: tap_idx wraps to 0, state -> OUTPUT. On the same edge: y_out/overflow <= sat(round(acc + sext(prod_in))) and y_valid <= 1. Latency is 1 cycle from the final product handshake to y_valid.
  - start is ignored in ACCUM.
- Round/saturate: r = (sum + 2^(FRAC-1)) >>> FRAC, an arithmetic shift giving round-half-up toward +inf.
  - r > 2^(OUT_W-1)-1 -> y_out = 511, overflow = 1.
  - r < -2^(OUT_W-1) -> y_out = -512, overflow = 1.
  - Otherwise y_out = r[OUT_W-1:0], overflow = 0.
- OUTPUT: y_valid=1, prod_ready=0. y_out and overflow are held stable until y_valid & y_ready.
  - On handshake, y_valid <= 0. If start=1 in the same cycle, next state is ACCUM (acc cleared, tap_idx=0, back-to-back frames). Otherwise next state is IDLE.
  - start without y_ready is ignored.
- y_out and overflow hold their last values in IDLE after the handshake.
- busy = (state != IDLE).

Test Plan:
1. start, then 16 products of 460 (20*23) with prod_valid continuous -> sum 7360; y_valid 1 cycle after 16th handshake; y_out=14 ((7360+256)>>>9), overflow=0; tap_idx 0..15 then 0.
2. 16 products of 0x40000 (+1.0) -> sum 2^22 -> r=8192 -> y_out=511 (10'h1FF), overflow=1.
3. 16 products of 0xC0000 (-1.0) -> r=-8192 -> y_out=-512 (10'h200), overflow=1. Also check 16 products of -1 -> sum -16 -> y_out=0.
4. prod_valid asserted every other cycle, values as test 1 -> identical y_out=14; acc and tap_idx change only on handshake cycles; completion takes 31 cycles after ACCUM entry.
5. Hold y_ready=0 for 5 cycles in OUTPUT with start pulsed -> y_out, y_valid, overflow stable; no new frame starts. Then y_ready=1 and start=1 together -> ACCUM next cycle, tap_idx=0, acc=0, prod_ready=1.
6. Assert rst_n low mid-edge after 7 products -> all outputs reset immediately, without waiting for clk. Release, start, feed test 1 data -> y_out=14, with no contamination from the aborted frame.
